// File: rtl/qar_uart_pkg.sv
// qar_uart_pkg: shared UART definitions for the RX and TX paths.
// Holds the FSM state encoding, frame width and default divider.
package qar_uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int CLOCK_HZ = 50_000_000;
  localparam logic [31:0] DEFAULT_BAUD_DIV =
    32'(CLOCK_HZ / 115200);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_t;

endpackage

// File: rtl/qar_uart_rx_if.sv
// qar_uart_rx_if: receiver <-> register file bus.
// master: receiver (drives data/status/pulses); slave: reg file (pop).
interface qar_uart_rx_if;
  import qar_uart_pkg::*;

  logic                      pop;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_full;
  logic                      frame_err;
  logic                      overrun;

  modport master (
    input  pop,
    output rx_data, rx_valid, rx_full,
    output frame_err, overrun
  );

  modport slave (
    output pop,
    input  rx_data, rx_valid, rx_full,
    input  frame_err, overrun
  );
endinterface

// File: rtl/qar_sync_fifo.sv
// qar_sync_fifo: show-ahead synchronous FIFO, pointer-difference flags.
// Ports: push/din write, pop read, head = oldest entry, full/empty.
module qar_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr[AW-1:0]];

  // A pop on a full FIFO frees the slot the push lands in.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/qar_uart_rx.sv
// qar_uart_rx: 8N1 receiver with synchronizer, FSM and RX FIFO.
// Ports: clk, rst_n, rx pin, enable, baud_div, bus (master side).
module qar_uart_rx
  import qar_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx,
  input  logic                enable,
  input  logic [31:0]         baud_div,
  qar_uart_rx_if.master       bus
);
  uart_state_t state;
  uart_state_t state_nx;

  logic                      sync1;
  logic                      rx_s;
  logic                      rx_s_d;
  logic [31:0]               cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      push;
  logic                      fifo_empty;
  logic                      fall;
  logic                      half_hit;
  logic                      bit_hit;
  logic                      sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      sync1  <= rx;
      rx_s   <= sync1;
      rx_s_d <= rx_s;
    end
  end

  assign fall     = rx_s_d & ~rx_s;
  assign half_hit = (cnt == (baud_div >> 1));
  assign bit_hit  = (cnt == baud_div);
  assign sample   =
    ((state == START) & half_hit) |
    (((state == DATA) | (state == STOP)) & bit_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (fall) state_nx = START;
        START:
          if (half_hit)
            state_nx = rx_s ? IDLE : DATA;
        DATA:
          if (bit_hit &&
              bit_idx == 3'(UART_DATA_BITS-1))
            state_nx = STOP;
        STOP:
          if (bit_hit)
            state_nx = rx_s ? IDLE : WAIT_IDLE;
        WAIT_IDLE:
          if (rx_s) state_nx = IDLE;
        default:
          state_nx = IDLE;
      endcase
    end
  end

  // The edge-detect cycle is count 0, so the counter enters
  // START at 1 and the start sample lands exactly H after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): cnt <= 32'd1;
        sample:          cnt <= '0;
        default:         cnt <= cnt + 32'd1;
      endcase
      if (state == START && half_hit)
        bit_idx <= '0;
      if (state == DATA && bit_hit) begin
        bit_idx <= bit_idx + 3'd1;
        shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
      end
    end
  end

  always_comb begin
    push          = 1'b0;
    bus.frame_err = 1'b0;
    bus.overrun   = 1'b0;
    if (state == STOP && bit_hit && enable) begin
      if (rx_s) begin
        push        = 1'b1;
        bus.overrun = bus.rx_full & ~bus.pop;
      end else begin
        bus.frame_err = 1'b1;
      end
    end
  end

  qar_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (bus.pop),
    .din   (shreg),
    .full  (bus.rx_full),
    .empty (fifo_empty),
    .head  (bus.rx_data)
  );

  assign bus.rx_valid = ~fifo_empty;
endmodule
